// File: rtl/quad_decoder_if.sv
// Bundles the encoder pins, clear request and decoded outputs of quad_decoder.
// Latency: none; plain wires between the board-side driver and the decoder.
// Backpressure: none; outputs are pulses/levels that the consumer samples as they come.
interface quad_decoder_if #(
  parameter int CNT_BITS = 8
);
  logic                enc_a;
  logic                enc_b;
  logic                clr;
  logic [CNT_BITS-1:0] count;
  logic                step_up;
  logic                step_dn;
  logic                err;

  // Board/user side: drives pins and clear, observes the decoded position.
  modport master (
    output enc_a, enc_b, clr,
    input  count, step_up, step_dn, err
  );

  // Decoder side.
  modport slave (
    input  enc_a, enc_b, clr,
    output count, step_up, step_dn, err
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop sync, per-channel debounce, Gray step decode, wrapping count.
// Latency: a clean pin change shows in count/pulses on the (2 + 2^DEBOUNCE_LOG2 + 1)-th clki edge.
// Backpressure: none; step/err pulses last one cycle and must be taken when they appear.
// Option: define QUAD_DECODER_X1_EN for 1x mode (one count per detent); default is 4x mode.
module quad_decoder #(
  parameter int CNT_BITS      = 8,
  parameter int DEBOUNCE_LOG2 = 4
) (
  input  logic          clki,
  input  logic          rst_n,
  quad_decoder_if.slave bus
);
  // Debounce fires when a counter at all-ones sees another mismatching cycle.
  localparam logic [DEBOUNCE_LOG2-1:0] DB_LAST   = '1;
  // INIT spans 2^DEBOUNCE_LOG2 + 2 cycles: index of its final cycle.
  localparam logic [DEBOUNCE_LOG2:0]   INIT_LAST =
    (DEBOUNCE_LOG2+1)'((1 << DEBOUNCE_LOG2) + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  logic [1:0]               sync_a, sync_b;
  logic                     sa, sb;
  logic                     fa, fb;
  logic [DEBOUNCE_LOG2-1:0] db_a, db_b;
  logic [DEBOUNCE_LOG2:0]   init_cnt;
  state_t                   state, state_nxt;
  logic [1:0]               p_new, p_old, delta;
  logic [CNT_BITS-1:0]      count_q, count_nxt;
  logic                     up_q, dn_q, err_q;
  logic                     up_nxt, dn_nxt, err_nxt;

  assign sa    = sync_a[1];
  assign sb    = sync_b[1];
  // Gray {a,b} -> binary position so that forward rotation counts 0,1,2,3.
  assign p_new = {fa, fa ^ fb};
  assign delta = p_new - p_old;

  // Two-flop synchronisers for the asynchronous encoder pins.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[0], bus.enc_a};
      sync_b <= {sync_b[0], bus.enc_b};
    end
  end

  // Times the INIT window; frozen once RUN is reached.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n)               init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
  end

  // Debounce filters: prime straight from the synchroniser in INIT, then
  // accept a level only after it has differed for 2^DEBOUNCE_LOG2 cycles.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      fa   <= 1'b0;
      fb   <= 1'b0;
      db_a <= '0;
      db_b <= '0;
    end else if (state == ST_INIT) begin
      fa   <= sa;
      fb   <= sb;
      db_a <= '0;
      db_b <= '0;
    end else begin
      if (sa == fa) begin
        db_a <= '0;
      end else if (db_a == DB_LAST) begin
        fa   <= sa;
        db_a <= '0;
      end else begin
        db_a <= db_a + 1'b1;
      end
      if (sb == fb) begin
        db_b <= '0;
      end else if (db_b == DB_LAST) begin
        fb   <= sb;
        db_b <= '0;
      end else begin
        db_b <= db_b + 1'b1;
      end
    end
  end

  // Previous filtered position; in INIT it tracks what the filter is loading
  // so the first RUN cycle sees no phantom step.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n)                p_old <= 2'd0;
    else if (state == ST_INIT) p_old <= {sa, sa ^ sb};
    else                       p_old <= p_new;
  end

  // FSM state register.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // Next state plus step decode; clear wins over a same-cycle step.
  always_comb begin
    state_nxt = state;
    count_nxt = count_q;
    up_nxt    = 1'b0;
    dn_nxt    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        case (delta)
          2'd1: begin
`ifdef QUAD_DECODER_X1_EN
            if (p_new == 2'd0) begin
              count_nxt = count_q + 1'b1;
              up_nxt    = 1'b1;
            end
`else
            count_nxt = count_q + 1'b1;
            up_nxt    = 1'b1;
`endif
          end
          2'd3: begin
`ifdef QUAD_DECODER_X1_EN
            if (p_new == 2'd0) begin
              count_nxt = count_q - 1'b1;
              dn_nxt    = 1'b1;
            end
`else
            count_nxt = count_q - 1'b1;
            dn_nxt    = 1'b1;
`endif
          end
          2'd2:    err_nxt = 1'b1;
          default: ;
        endcase
      end
      default: state_nxt = ST_INIT;
    endcase
    if (bus.clr) count_nxt = '0;
  end

  // Registered outputs.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      up_q    <= up_nxt;
      dn_q    <= dn_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.count   = count_q;
  assign bus.step_up = up_q;
  assign bus.step_dn = dn_q;
  assign bus.err     = err_q;
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Reads a 2-channel quadrature (Gray-coded) rotary encoder from board input pins and maintains a signed-agnostic up/down position count.
- It is the input-side counterpart of the LED Gray-count output path: it decodes a Gray sequence where that path encodes one.
- Pipeline: pin synchroniser, per-channel debounce filter, Gray-to-binary step decode, wrapping counter.
- Sits between board pins and user logic, for example driving LED patterns or a menu index.

Parameters:
- CNT_BITS, 8: width of the position counter.
- DEBOUNCE_LOG2, 4: a channel must hold a new level for 2^DEBOUNCE_LOG2 consecutive cycles before it is accepted (legal range 1..16).

Ports:
- clki  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enc_a  input  1  encoder channel A, asynchronous to clki.
- enc_b  input  1  encoder channel B, asynchronous to clki.
- clr  input  1  synchronous clear of count.
- count  output  CNT_BITS  position count; wraps modulo 2^CNT_BITS.
- step_up  output  1  one-cycle pulse, one up step accepted.
- step_dn  output  1  one-cycle pulse, one down step accepted.
- err  output  1  one-cycle pulse, illegal transition (both channels changed together).

Behaviour:
- Reset (asynchronous on rst_n low):
  - Synchroniser flops, filtered state {fa,fb} and debounce counters clear to 0.
  - count = 0; step_up = step_dn = err = 0; FSM enters INIT.
- Synchroniser:
  - 2 flops per channel; sa/sb are the second-stage outputs.
- Debounce, per channel, independent:
  - A counter of DEBOUNCE_LOG2 bits clears whenever s == f.
  - While s != f, the counter increments each cycle.
  - On the edge where the counter would reach 2^DEBOUNCE_LOG2, f <= s and the counter clears.
  - A glitch shorter than 2^DEBOUNCE_LOG2 cycles never reaches f.
- FSM INIT:
  - Lasts exactly 2^DEBOUNCE_LOG2 + 2 cycles after rst_n deasserts, timed by a dedicated counter.
  - f loads s directly every cycle, so the filter primes to the encoder's resting position.
  - No count changes, no pulses, err suppressed.
  - Then go to RUN.
- FSM RUN, decode:
  - Position p = {fa, fa^fb}. Let p_old be the registered previous filtered position and d = p_new - p_old mod 4.
  - d=0: nothing.
  - d=1: count+1, step_up.
  - d=3: count-1, step_dn.
  - d=2: err pulse, count unchanged, p_old still updated.
  - Forward sequence {a,b}: 00 -> 01 -> 11 -> 10 -> 00.
- Latency:
  - A clean level change held on a pin is reflected in count and pulses on the (2 + 2^DEBOUNCE_LOG2 + 1)-th rising edge after it is first sampled.
  - With DEBOUNCE_LOG2=2 this is the 7th edge.
- Pulses are registered and high for exactly one cycle per accepted transition.
- Wrap-around: all-ones + 1 -> 0; 0 - 1 -> all-ones. No saturation.
- clr:
  - Sets count to 0 on the next edge and overrides a same-cycle step.
  - step_up/step_dn/err still pulse normally.
  - clr has no effect on filter or FSM.
- Reset mid-operation: returns to INIT, and all in-flight debounce progress is lost.
- All outputs are driven from flops; no combinational path from inputs to outputs.

Optional Feature:
- QUAD_DECODER_X1_EN
- Defined (1x mode):
  - Count and step pulses occur only on transitions into filtered state {a,b}=00: from 10 is up, from 01 is down.
  - This gives one count per detent.
  - Other legal transitions only update p_old.
  - err behaviour is unchanged.
- Undefined (default, 4x mode): every legal transition counts as described in Behaviour.

Test Plan:
(All scenarios use DEBOUNCE_LOG2=2 and CNT_BITS=8 unless noted.)
- Reset/INIT: hold encoder at 11 through reset, release rst_n, wait 10 cycles -> count=0x00, no step_up/step_dn/err pulse at any time.
- Forward rotation: after INIT, drive 00->01->11->10->00, each state held 12 cycles -> four step_up pulses, count=0x04. Measure the first pulse on the 7th edge after the pin change.
- Reverse and wrap: from count=0, drive 00->10 -> count=0xFF with one step_dn. Then drive back 10->00 -> count=0x00 with one step_up.
- Debounce: toggle enc_a for 3 cycles, then restore it, repeating 5 times -> count and pulses unchanged. Then hold the change for 4 cycles -> exactly one step.
- Illegal transition: from 00, switch enc_a and enc_b to 11 in the same cycle -> one err pulse, count unchanged. A subsequent 11->10 gives step_up.
- clr collision, plus async reset mid-debounce:
  - Assert clr in the same cycle as a decoded step_up with count=0x05 -> count=0x00 and step_up pulse present.
  - Pulse rst_n low for 1 cycle mid-debounce -> outputs clear immediately and INIT re-runs.
- With QUAD_DECODER_X1_EN defined: one full forward cycle -> exactly one step_up, count=0x01.
